// File: rtl/bomb_pkg.sv
// Shared definitions for the BCD countdown sequencer: controller states,
// BCD digit constants and the preset digit clamp.
package bomb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DEC     = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_EXPIRED = 3'd4
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Out-of-range preset digits saturate to the largest legal BCD digit.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Single BCD digit decrement: zero wraps to nine and raises borrow_out so the
// caller moves on to the next more significant digit.
module bcd_digit_step
    import bomb_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out,
    output logic       borrow_out
);

    always_comb begin
        borrow_out = (digit_in == BCD_ZERO);
        digit_out  = borrow_out ? BCD_MAX : (digit_in - 4'd1);
    end

endmodule

// File: rtl/bcd_countdown_sequencer.sv
// Countdown controller over a bank of BCD digits; each accepted tick borrows
// serially from the least significant digit, one digit per clock.
module bcd_countdown_sequencer
    import bomb_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                async_nreset,
    input  logic                load,
    input  logic [4*DIGITS-1:0] preset,
    input  logic                start,
    input  logic                pause,
    input  logic                tick,
    output logic [4*DIGITS-1:0] count,
    output logic                running,
    output logic                expired,
    output logic                done,
    output logic                overrun
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t              state, next_state;
    logic [IDX_W-1:0]    idx, next_idx;
    logic                pause_seen, next_pause_seen;
    logic [4*DIGITS-1:0] next_count;
    logic                next_overrun;

    logic [3:0]          cur_digit;
    logic [3:0]          step_digit;
    logic                step_borrow;
    logic [4*DIGITS-1:0] stepped_count;
    logic [4*DIGITS-1:0] clamped_preset;
    logic                count_zero;
    logic                stepped_zero;

    // Digit under the borrow pointer, and the bank with that digit stepped.
    always_comb begin
        cur_digit     = BCD_ZERO;
        stepped_count = count;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit                = count[4*i +: 4];
                stepped_count[4*i +: 4]  = step_digit;
            end
        end
    end

    bcd_digit_step u_digit_step (
        .digit_in   (cur_digit),
        .digit_out  (step_digit),
        .borrow_out (step_borrow)
    );

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            clamped_preset[4*i +: 4] = bcd_clamp(preset[4*i +: 4]);
        end
    end

    assign count_zero   = (count == '0);
    assign stepped_zero = (stepped_count == '0);

    // NOTE: every signal this block drives gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        next_state      = state;
        next_count      = count;
        next_idx        = idx;
        next_pause_seen = pause_seen;
        next_overrun    = overrun;

        if (load) begin
            next_state      = ST_IDLE;
            next_count      = clamped_preset;
            next_idx        = '0;
            next_pause_seen = 1'b0;
            next_overrun    = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_PAUSED: begin
                    if (start && !pause) begin
                        next_state = count_zero ? ST_EXPIRED : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        next_state = ST_PAUSED;
                    end else if (tick) begin
                        next_state      = ST_DEC;
                        next_idx        = '0;
                        next_pause_seen = 1'b0;
                    end
                end
                ST_DEC: begin
                    if (tick) begin
                        next_overrun = 1'b1;
                    end
                    next_pause_seen = pause_seen | pause;
                    next_count      = stepped_count;
                    if (step_borrow) begin
                        next_idx = idx + IDX_W'(1);
                    end else begin
                        next_idx = '0;
                        if (stepped_zero) begin
                            next_state = ST_EXPIRED;
                        end else if (pause_seen || pause) begin
                            next_state = ST_PAUSED;
                        end else begin
                            next_state = ST_RUN;
                        end
                    end
                end
                ST_EXPIRED: begin
                    next_state = ST_EXPIRED;
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state      <= ST_IDLE;
            count      <= '0;
            idx        <= '0;
            pause_seen <= 1'b0;
            overrun    <= 1'b0;
            running    <= 1'b0;
            expired    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= next_state;
            count      <= next_count;
            idx        <= next_idx;
            pause_seen <= next_pause_seen;
            overrun    <= next_overrun;
            running    <= (next_state == ST_RUN) || (next_state == ST_DEC);
            expired    <= (next_state == ST_EXPIRED);
            done       <= (next_state == ST_EXPIRED) && (state != ST_EXPIRED);
        end
    end

endmodule

// File: tb/tb_bcd_countdown_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a
// decimal-arithmetic reference model of the countdown.
module tb_bcd_countdown_sequencer;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_BUSY    = 2;
    localparam int M_PAUSED  = 3;
    localparam int M_EXPIRED = 4;

    logic         clk = 1'b0;
    logic         async_nreset;
    logic         load, start, pause, tick;
    logic [W-1:0] preset;
    logic [W-1:0] count;
    logic         running, expired, done, overrun;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: decimal value, mode, digits borrowed so far.
    int m_value;
    int m_mode;
    int m_j;
    bit m_pause_seen;
    bit m_overrun;
    bit m_done;

    always #5 clk = ~clk;

    bcd_countdown_sequencer #(.DIGITS(DIGITS)) dut (
        .clk          (clk),
        .async_nreset (async_nreset),
        .load         (load),
        .preset       (preset),
        .start        (start),
        .pause        (pause),
        .tick         (tick),
        .count        (count),
        .running      (running),
        .expired      (expired),
        .done         (done),
        .overrun      (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int preset_value(input logic [W-1:0] p);
        int v = 0;
        for (int i = 0; i < DIGITS; i++) begin
            int d = int'(p[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * pow10(i);
        end
        return v;
    endfunction

    function automatic int lowest_nonzero(input int v);
        int k = 0;
        while (k < DIGITS - 1 && (v % 10) == 0) begin
            v = v / 10;
            k++;
        end
        return k;
    endfunction

    function automatic int shown_value();
        int p;
        if (m_mode != M_BUSY) return m_value;
        p = pow10(m_j);
        return (m_value / p) * p + p - 1;
    endfunction

    task automatic model_reset();
        m_value = 0; m_mode = M_IDLE; m_j = 0;
        m_pause_seen = 0; m_overrun = 0; m_done = 0;
    endtask

    task automatic model_update(input bit l, input logic [W-1:0] p, input bit s,
                                input bit pa, input bit t);
        m_done = 0;
        if (l) begin
            m_value = preset_value(p); m_mode = M_IDLE; m_overrun = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_PAUSED:
                    if (s && !pa) begin
                        if (m_value == 0) begin m_mode = M_EXPIRED; m_done = 1; end
                        else m_mode = M_RUN;
                    end
                M_RUN:
                    if (pa) m_mode = M_PAUSED;
                    else if (t) begin m_mode = M_BUSY; m_j = 0; m_pause_seen = 0; end
                M_BUSY: begin
                    if (t) m_overrun = 1;
                    m_pause_seen = m_pause_seen | pa;
                    if (m_j == lowest_nonzero(m_value)) begin
                        m_value = m_value - 1;
                        if (m_value == 0) begin m_mode = M_EXPIRED; m_done = 1; end
                        else if (m_pause_seen) m_mode = M_PAUSED;
                        else m_mode = M_RUN;
                    end else begin
                        m_j++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".count"},   32'(count),   32'(to_bcd(shown_value())));
        check({tag, ".running"}, 32'(running), 32'(m_mode == M_RUN || m_mode == M_BUSY));
        check({tag, ".expired"}, 32'(expired), 32'(m_mode == M_EXPIRED));
        check({tag, ".done"},    32'(done),    32'(m_done));
        check({tag, ".overrun"}, 32'(overrun), 32'(m_overrun));
    endtask

    // Called at a falling edge; drives inputs, advances the model, checks after the rising edge.
    task automatic step(input string tag, input bit l, input logic [W-1:0] p,
                        input bit s, input bit pa, input bit t);
        load = l; preset = p; start = s; pause = pa; tick = t;
        model_update(l, p, s, pa, t);
        @(posedge clk);
        #1;
        compare_all(tag);
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, '0, 0, 0, 0);
    endtask

    function automatic logic [W-1:0] rand_preset();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            if ($urandom_range(0, 9) == 0) r[4*i +: 4] = 4'($urandom_range(0, 15));
            else r[4*i +: 4] = 4'($urandom_range(0, 2));
        end
        return r;
    endfunction

    initial begin
        async_nreset = 1'b0;
        load = 0; start = 0; pause = 0; tick = 0; preset = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        async_nreset = 1'b1;
        idle("post_reset", 2);

        // Single-digit decrement.
        step("l0102", 1, 16'h0102, 0, 0, 0);
        step("s0102", 0, '0, 1, 0, 0);
        step("t0102", 0, '0, 0, 0, 1);
        step("d0102", 0, '0, 0, 0, 0);
        check("lit_0101", 32'(count), 32'h0101);
        check("lit_0101_run", 32'(running), 32'd1);

        // Full-width borrow: result visible exactly four cycles after the tick.
        step("l1000", 1, 16'h1000, 0, 0, 0);
        step("s1000", 0, '0, 1, 0, 0);
        step("t1000", 0, '0, 0, 0, 1);
        idle("d1000", 3);
        check("lit_not_yet", 32'(count == 16'h0999), 32'd0);
        step("d1000_end", 0, '0, 0, 0, 0);
        check("lit_0999", 32'(count), 32'h0999);
        check("lit_0999_ovr", 32'(overrun), 32'd0);

        // Expiry from 1, done lasts one cycle, expired is sticky.
        step("l0001", 1, 16'h0001, 0, 0, 0);
        step("s0001", 0, '0, 1, 0, 0);
        step("t0001", 0, '0, 0, 0, 1);
        step("d0001", 0, '0, 0, 0, 0);
        check("lit_done", 32'(done), 32'd1);
        step("e0001", 0, '0, 0, 0, 0);
        check("lit_done_gone", 32'(done), 32'd0);
        step("e_tick", 0, '0, 0, 0, 1);
        step("e_start", 0, '0, 1, 0, 1);
        check("lit_zero_hold", 32'(count), 32'h0000);
        check("lit_exp_hold", 32'(expired), 32'd1);

        // Clamp and start on zero.
        step("l00A3", 1, 16'h00A3, 0, 0, 0);
        check("lit_clamp", 32'(count), 32'h0093);
        step("l0000", 1, 16'h0000, 0, 0, 0);
        step("s0000", 0, '0, 1, 0, 0);
        check("lit_zero_exp", 32'(expired), 32'd1);

        // Overrun, pause during borrow, start+pause priority.
        step("l0100", 1, 16'h0100, 0, 0, 0);
        step("s0100", 0, '0, 1, 0, 0);
        step("t0100", 0, '0, 0, 0, 1);
        step("t0100b", 0, '0, 0, 0, 1);
        idle("d0100", 2);
        check("lit_0099", 32'(count), 32'h0099);
        check("lit_ovr", 32'(overrun), 32'd1);
        step("t0099", 0, '0, 0, 0, 1);
        step("p0099", 0, '0, 0, 1, 0);
        idle("d0099", 1);
        check("lit_paused", 32'(running), 32'd0);
        step("sp0098", 0, '0, 1, 1, 0);
        step("s0098", 0, '0, 1, 0, 0);

        // Load mid-borrow.
        step("l1000b", 1, 16'h1000, 0, 0, 0);
        step("s1000b", 0, '0, 1, 0, 0);
        step("t1000b", 0, '0, 0, 0, 1);
        idle("d1000b", 1);
        step("lmid", 1, 16'h0042, 0, 0, 0);
        check("lit_load_mid", 32'(count), 32'h0042);

        // Asynchronous reset mid-borrow.
        step("l1000c", 1, 16'h1000, 0, 0, 0);
        step("s1000c", 0, '0, 1, 0, 0);
        step("t1000c", 0, '0, 0, 0, 1);
        idle("d1000c", 1);
        #2 async_nreset = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clk);
        async_nreset = 1'b1;
        idle("after_rst", 2);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            step("rnd",
                 $urandom_range(0, 99) < 4,
                 rand_preset(),
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 35);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
